// File: rtl/fpu_pkg.sv
// Shared FPU definitions: multiplier latency, FP16 constants and the
// requester tag carried alongside each multiply.
package fpu_pkg;

  localparam int unsigned FPU_MULT_LAT = 3;
  localparam logic [15:0] FP16_QNAN    = 16'h7E00;
  localparam int unsigned FPU_ID_W     = 2;

  typedef logic [FPU_ID_W-1:0] fpu_id_t;

  typedef struct packed {
    logic    valid;
    fpu_id_t id;
  } fpu_tag_t;

endpackage

// File: rtl/fpu_arb_fifo.sv
// Synchronous show-ahead FIFO: head_data always presents the oldest entry;
// count reports occupancy. Caller guarantees no push when full / pop when empty.
module fpu_arb_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fpu_mult_arbiter.sv
// Round-robin front end sharing one pipelined FP16 multiplier among NUM_REQ
// requesters; results return in issue order through a credit-protected FIFO.
module fpu_mult_arbiter
  import fpu_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned MULT_LAT   = FPU_MULT_LAT,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]    resp_valid,
  input  logic [NUM_REQ-1:0]    resp_ready,
  output logic [31:0]           resp_result,
  output logic                  mult_valid_in,
  output logic [31:0]           mult_a,
  output logic [31:0]           mult_b,
  input  logic                  mult_valid_out,
  input  logic [31:0]           mult_result,
  output logic                  busy,
  output logic                  err_orphan
);

  localparam int unsigned IDW = $clog2(NUM_REQ);
  localparam int unsigned CW  = $clog2(FIFO_DEPTH+1);
  localparam int unsigned IFW = $clog2(MULT_LAT+1);

  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   winner;
  logic [IDW-1:0]   cand;
  int unsigned      idx;
  logic             found;
  logic             credit_ok;
  logic             grant;
  logic [31:0]      sel_a;
  logic [31:0]      sel_b;

  fpu_tag_t         tag_pipe [MULT_LAT];
  fpu_tag_t         tag_in;
  fpu_tag_t         tail;
  logic [IFW-1:0]   in_flight;

  logic             fifo_push;
  logic             fifo_pop;
  logic [IDW+31:0]  fifo_head;
  logic [CW-1:0]    fifo_count;
  logic             fifo_nonempty;
  logic [IDW-1:0]   head_id;

  // Credit uses registered counts only, so a same-cycle pop never frees a slot.
  assign credit_ok = (32'(fifo_count) + 32'(in_flight)) < FIFO_DEPTH;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    cand   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx  = (32'(rr_ptr) + k) % NUM_REQ;
      cand = IDW'(idx);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Gated by rst_n: an operation granted during reset would be discarded.
  assign grant = found & credit_ok & rst_n;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (IDW'(k) == winner) begin
        sel_a = req_a[k*32 +: 32];
        sel_b = req_b[k*32 +: 32];
      end
    end
  end

  assign req_ready     = grant ? (NUM_REQ'(1) << winner) : '0;
  assign mult_valid_in = grant;
  assign mult_a        = grant ? sel_a : '0;
  assign mult_b        = grant ? sel_b : '0;

  always_comb begin
    tag_in       = '0;
    tag_in.valid = grant;
    tag_in.id    = FPU_ID_W'(winner);
  end

  assign tail = tag_pipe[MULT_LAT-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MULT_LAT; i++) tag_pipe[i] <= '0;
      in_flight  <= '0;
      rr_ptr     <= '0;
      err_orphan <= 1'b0;
    end else begin
      tag_pipe[0] <= tag_in;
      for (int unsigned i = 1; i < MULT_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
      unique case ({grant, tail.valid})
        2'b10:   in_flight <= in_flight + IFW'(1);
        2'b01:   in_flight <= in_flight - IFW'(1);
        default: in_flight <= in_flight;
      endcase
      if (grant) rr_ptr <= (winner == IDW'(NUM_REQ-1)) ? '0 : winner + 1'b1;
      if (mult_valid_out ^ tail.valid) err_orphan <= 1'b1;
    end
  end

  assign fifo_push = mult_valid_out & tail.valid;

  fpu_arb_fifo #(
    .WIDTH (IDW + 32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data ({tail.id[IDW-1:0], mult_result}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .count     (fifo_count)
  );

  assign fifo_nonempty = (fifo_count != '0);
  assign head_id       = fifo_head[32 +: IDW];
  assign resp_valid    = fifo_nonempty ? (NUM_REQ'(1) << head_id) : '0;
  assign resp_result   = fifo_nonempty ? fifo_head[31:0] : '0;
  assign fifo_pop      = fifo_nonempty & resp_ready[head_id];

  assign busy = (in_flight != '0) || fifo_nonempty;

endmodule

// File: tb/tb_fpu_mult_arbiter.sv
// Directed bench for fpu_mult_arbiter with a 3-stage table-driven FP16
// multiplier model standing in for fpu_mult_pipelined.
module tb_fpu_mult_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [31:0] resp_result;
  logic        mult_valid_in;
  logic [31:0] mult_a;
  logic [31:0] mult_b;
  logic        mult_valid_out;
  logic [31:0] mult_result;
  logic        busy;
  logic        err_orphan;
  logic        inject;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fpu_mult_arbiter #(
    .NUM_REQ    (2),
    .MULT_LAT   (3),
    .FIFO_DEPTH (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_a          (req_a),
    .req_b          (req_b),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_result    (resp_result),
    .mult_valid_in  (mult_valid_in),
    .mult_a         (mult_a),
    .mult_b         (mult_b),
    .mult_valid_out (mult_valid_out),
    .mult_result    (mult_result),
    .busy           (busy),
    .err_orphan     (err_orphan)
  );

  // Hand-computed FP16 products for the operand pairs the bench uses.
  function automatic logic [31:0] fp16_mul(input logic [31:0] a, input logic [31:0] b);
    if (a[15:0] == 16'h3C00) return {16'h0, b[15:0]};
    if (a[15:0] == 16'h4000 && b[15:0] == 16'h4200) return 32'h0000_4600;
    if (a[15:0] == 16'h3E00 && b[15:0] == 16'h3E00) return 32'h0000_4080;
    if (a[15:0] == 16'hC000 && b[15:0] == 16'h3800) return 32'h0000_BC00;
    if (a[15:0] == 16'h7C00 && b[15:0] == 16'h0000) return 32'h0000_7E00;
    return 32'hDEAD_BEEF;
  endfunction

  logic [2:0]  mv;
  logic [31:0] mr [3];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mv    <= '0;
      mr[0] <= '0;
      mr[1] <= '0;
      mr[2] <= '0;
    end else begin
      mv    <= {mv[1:0], mult_valid_in};
      mr[0] <= fp16_mul(mult_a, mult_b);
      mr[1] <= mr[0];
      mr[2] <= mr[1];
    end
  end

  assign mult_valid_out = mv[2] | inject;
  assign mult_result    = mr[2];

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    req_valid  = 2'b11;
    req_a      = {32'h3C00, 32'h3C00};
    req_b      = {32'h4000, 32'h4000};
    resp_ready = '0;
    repeat (3) @(negedge clk);
    #1;
    tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
    tests++; if (resp_valid !== 2'b00) begin fails++; $display("FAIL reset_resp_valid got=%b exp=00", resp_valid); end
    tests++; if (mult_valid_in !== 1'b0) begin fails++; $display("FAIL reset_mult_valid_in got=%b exp=0", mult_valid_in); end
    tests++; if (resp_result !== 32'h0) begin fails++; $display("FAIL reset_resp_result got=%h exp=0", resp_result); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests++; if (err_orphan !== 1'b0) begin fails++; $display("FAIL reset_err_orphan got=%b exp=0", err_orphan); end
    req_valid = '0;
    rst_n     = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int          first;
    logic [1:0]  gv;
    logic [31:0] got;
    first = 0; gv = '0; got = '0;
    @(negedge clk);
    req_valid  = 2'b01;
    req_a      = {32'h0, 32'h4000};
    req_b      = {32'h0, 32'h4200};
    resp_ready = 2'b11;
    #1;
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL single_grant got=%b exp=01", req_ready); end
    tests++; if ({mult_valid_in, mult_a, mult_b} !== {1'b1, 32'h4000, 32'h4200})
      begin fails++; $display("FAIL single_issue got=%b/%h/%h exp=1/4000/4200", mult_valid_in, mult_a, mult_b); end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      if (k == 1) begin
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy got=%b exp=1", busy); end
      end
      if (first == 0 && resp_valid !== 2'b00) begin
        first = k; gv = resp_valid; got = resp_result;
      end
    end
    tests++; if (first != 4) begin fails++; $display("FAIL single_latency got=%0d exp=4", first); end
    tests++; if (gv !== 2'b01) begin fails++; $display("FAIL single_resp_id got=%b exp=01", gv); end
    tests++; if (got !== 32'h0000_4600) begin fails++; $display("FAIL single_result got=%h exp=00004600", got); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_idle got=%b exp=0", busy); end
  endtask

  task automatic test_contention();
    logic [1:0]  exp_g [4];
    logic [31:0] exp_r [4];
    logic [1:0]  rv [8];
    logic [31:0] rr [8];
    int          n;
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    exp_r[0] = 32'h4080; exp_r[1] = 32'hBC00; exp_r[2] = 32'h4080; exp_r[3] = 32'hBC00;
    n = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_valid  = 2'b11;
      req_a      = {32'hC000, 32'h3E00};
      req_b      = {32'h3800, 32'h3E00};
      resp_ready = 2'b11;
      #1;
      tests++; if (req_ready !== exp_g[i]) begin fails++; $display("FAIL cont_grant[%0d] got=%b exp=%b", i, req_ready, exp_g[i]); end
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      if (resp_valid !== 2'b00 && n < 8) begin
        rv[n] = resp_valid; rr[n] = resp_result; n++;
      end
    end
    tests++; if (n != 4) begin fails++; $display("FAIL cont_resp_count got=%0d exp=4", n); end
    for (int i = 0; i < 4 && i < n; i++) begin
      tests++;
      if (rv[i] !== exp_g[i] || rr[i] !== exp_r[i]) begin
        fails++; $display("FAIL cont_resp[%0d] got=%b/%h exp=%b/%h", i, rv[i], rr[i], exp_g[i], exp_r[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int          grants, g2, pops, nb;
    logic [31:0] recv [32];
    grants = 0; g2 = 0; pops = 0; nb = 0;
    resp_ready = 2'b00;
    req_a = {32'h0, 32'h3C00};
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      req_valid = 2'b01;
      req_b     = {32'h0, 32'h4000 + 32'(nb)};
      #1;
      if (req_ready[0]) begin grants++; nb++; end
    end
    tests++; if (grants != 4) begin fails++; $display("FAIL bp_grants got=%0d exp=4", grants); end
    tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL bp_stall got=%b exp=00", req_ready); end
    tests++; if (resp_valid !== 2'b01 || resp_result !== 32'h4000)
      begin fails++; $display("FAIL bp_head got=%b/%h exp=01/00004000", resp_valid, resp_result); end
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      req_valid  = (k < 8) ? 2'b01 : 2'b00;
      req_b      = {32'h0, 32'h4000 + 32'(nb)};
      resp_ready = 2'b01;
      #1;
      if (req_ready[0]) begin grants++; g2++; nb++; end
      if (resp_valid[0] && pops < 32) begin recv[pops] = resp_result; pops++; end
    end
    tests++; if (g2 == 0) begin fails++; $display("FAIL bp_resume got=%0d exp=>0", g2); end
    tests++; if (pops != grants) begin fails++; $display("FAIL bp_count got=%0d exp=%0d", pops, grants); end
    for (int i = 0; i < pops; i++) begin
      tests++;
      if (recv[i] !== 32'h4000 + 32'(i)) begin
        fails++; $display("FAIL bp_order[%0d] got=%h exp=%h", i, recv[i], 32'h4000 + 32'(i));
      end
    end
  endtask

  task automatic test_special();
    int          first;
    logic [1:0]  gv;
    logic [31:0] got;
    first = 0; gv = '0; got = '0;
    @(negedge clk);
    req_valid  = 2'b10;
    req_a      = {32'h7C00, 32'h0};
    req_b      = {32'h0000, 32'h0};
    resp_ready = 2'b11;
    #1;
    tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL special_grant got=%b exp=10", req_ready); end
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      if (first == 0 && resp_valid !== 2'b00) begin first = k; gv = resp_valid; got = resp_result; end
    end
    tests++; if (gv !== 2'b10 || got !== 32'h0000_7E00)
      begin fails++; $display("FAIL special_result got=%b/%h exp=10/00007e00", gv, got); end
  endtask

  task automatic test_reset_midflight();
    int stray;
    stray = 0;
    resp_ready = 2'b11;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      req_valid = 2'b01;
      req_a     = {32'h0, 32'h4000};
      req_b     = {32'h0, 32'h4200};
      #1;
      tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL mid_grant[%0d] got=%b exp=01", i, req_ready); end
    end
    @(negedge clk);
    req_valid = '0;
    rst_n     = 1'b0;
    @(negedge clk);
    #1;
    tests++; if ({busy, resp_valid, req_ready, mult_valid_in, err_orphan} !== 7'b0 || resp_result !== 32'h0)
      begin fails++; $display("FAIL mid_reset_outputs got=%b%b%b%b%b/%h exp=0000000/0", busy, resp_valid, req_ready, mult_valid_in, err_orphan, resp_result); end
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      if (resp_valid !== 2'b00 || busy !== 1'b0) stray++;
    end
    tests++; if (stray != 0) begin fails++; $display("FAIL mid_no_resp got=%0d exp=0", stray); end
    tests++; if (err_orphan !== 1'b0) begin fails++; $display("FAIL mid_err_orphan got=%b exp=0", err_orphan); end
  endtask

  task automatic test_orphan();
    @(negedge clk);
    inject = 1'b1;
    #1;
    tests++; if (err_orphan !== 1'b0) begin fails++; $display("FAIL orphan_pre got=%b exp=0", err_orphan); end
    @(negedge clk);
    inject = 1'b0;
    #1;
    tests++; if (err_orphan !== 1'b1) begin fails++; $display("FAIL orphan_set got=%b exp=1", err_orphan); end
    tests++; if (busy !== 1'b0 || resp_valid !== 2'b00)
      begin fails++; $display("FAIL orphan_fifo got=%b/%b exp=0/00", busy, resp_valid); end
    repeat (3) @(negedge clk);
    #1;
    tests++; if (err_orphan !== 1'b1) begin fails++; $display("FAIL orphan_sticky got=%b exp=1", err_orphan); end
    do_reset();
    #1;
    tests++; if (err_orphan !== 1'b0) begin fails++; $display("FAIL orphan_clear got=%b exp=0", err_orphan); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout sim_time=%0t", $time);
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = '0;
    inject     = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_special();
    test_reset_midflight();
    test_orphan();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
